// File: rtl/memoria_pkg.sv
// Shared definitions for the main-memory controller: width defaults, latency bounds, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package memoria_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 3;
    localparam int LATENCY_DEF = 3;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of the latency counter: enough to hold LATENCY-1, never less than one bit.
    function automatic int cnt_width(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/contador_latencia.sv
// Loadable down-counter timing one memory access; zero flags the completing edge.
// Latency: load/decrement take effect at the next clock edge; zero is decoded from the count register.
// Backpressure: none; the counter stops at zero until reloaded.
//
// Ports: clock, resetn (async active-low), load/load_val (synchronous load, wins over en),
//        en (decrement when nonzero), zero (count == 0).
module contador_latencia #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/memoria_principal_ctrl.sv
// Main-memory backing store + controller: optional victim write-back followed by a line fill.
// Latency: LATENCY cycles per access; ack in the cycle after edge E0+LATENCY (read) or E0+2*LATENCY (wb+read).
// Backpressure: ready=0 from the cycle after acceptance through the ack cycle; req is ignored while busy.
//
// Ports: clock, resetn (async active-low); req/wb_en/wb_addr/wb_data/rd_addr request fields
//        (sampled only on the accepting edge); ready, ack (1-cycle pulse), rd_data (held until next ack).
// Optional macro MEMPRINC_STATS_EN adds rd_count / wb_count (saturating at 255).
module memoria_principal_ctrl
    import memoria_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rd_data
`ifdef MEMPRINC_STATS_EN
    ,
    output logic [7:0]        rd_count,
    output logic [7:0]        wb_count
`endif
);

    localparam int              DEPTH  = 2 ** ADDR_W;
    localparam int              CNT_W  = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_range
            $error("memoria_principal_ctrl: LATENCY must be within 1..15");
        end
    endgenerate

    state_t state, state_next;

    logic              wb_en_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [ADDR_W-1:0] rd_addr_q;

    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;
    logic wr_en;
    logic rd_en;
    logic accept;

    logic [DATA_W-1:0] mem [DEPTH];

    contador_latencia #(.W(CNT_W)) u_contador (
        .clock    (clock),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (RELOAD),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    assign accept = (state == IDLE) && req;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The WB phase reloads the shared counter on its final edge so RD gets a full LATENCY.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_load   = 1'b1;
                    state_next = wb_en ? WB : RD;
                end
            end
            WB: begin
                if (cnt_zero) begin
                    wr_en      = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = RD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RD: begin
                if (cnt_zero) begin
                    rd_en      = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ready/ack are flopped from the next state so no output is a decode of live logic.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready <= 1'b1;
            ack   <= 1'b0;
        end else begin
            ready <= (state_next == IDLE);
            ack   <= (state_next == DONE);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            rd_addr_q <= '0;
        end else if (accept) begin
            wb_en_q   <= wb_en;
            wb_addr_q <= wb_addr;
            wb_data_q <= wb_data;
            rd_addr_q <= rd_addr;
        end
    end

    // Reset loads word i with i so post-reset contents are known.
    // The write lands on an earlier edge than the read, so a same-address
    // fill naturally returns the victim data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (wr_en && wb_en_q) begin
            mem[wb_addr_q] <= wb_data_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr_q];
        end
    end

`ifdef MEMPRINC_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_count <= '0;
            wb_count <= '0;
        end else begin
            if (rd_en && (rd_count != 8'hFF)) begin
                rd_count <= rd_count + 8'd1;
            end
            if (wr_en && (wb_count != 8'hFF)) begin
                wb_count <= wb_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memoria_principal_ctrl.sv
// Bench for memoria_principal_ctrl: directed and random transactions against a word-array model.
// Latency: expected ack cycle is derived from the acceptance edge and LATENCY.
// Backpressure: request fields are scrambled and req pulsed while busy; they must be ignored.
module tb_memoria_principal_ctrl;

    localparam int AW  = 5;
    localparam int DW  = 3;
    localparam int LAT = 3;

    logic          clock   = 1'b0;
    logic          resetn  = 1'b0;
    logic          req     = 1'b0;
    logic          wb_en   = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          ready;
    logic          ack;
    logic [DW-1:0] rd_data;
`ifdef MEMPRINC_STATS_EN
    logic [7:0]    rd_count;
    logic [7:0]    wb_count;
`endif

    memoria_principal_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .req     (req),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rd_addr (rd_addr),
        .ready   (ready),
        .ack     (ack),
        .rd_data (rd_data)
`ifdef MEMPRINC_STATS_EN
        ,
        .rd_count(rd_count),
        .wb_count(wb_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    int            checks    = 0;
    int            errors    = 0;
    int            cyc       = 0;
    int            acks_seen = 0;
    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] mem_m [2**AW];
    int            rd_m;
    int            wb_m;
    logic [DW-1:0] last_rd;

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (resetn && ack) begin
            acks_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_rd_data", 32'(rd_data), 32'(mon_e.data));
                chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) mem_m[i] = DW'(i);
        rd_m    = 0;
        wb_m    = 0;
        last_rd = '0;
        sb.delete();
    endtask

    task automatic check_idle_after_reset(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
`ifdef MEMPRINC_STATS_EN
        chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        chk({tag, "_wb_count"}, 32'(wb_count), 32'd0);
`endif
    endtask

    // Issue one transaction from an idle controller; called at negedge+1.
    task automatic txn(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input bit scramble);
        exp_t e;
        int   target;
        int   waited;
        chk("ready_before_req", 32'(ready), 32'd1);
        req     = 1'b1;
        wb_en   = w;
        wb_addr = wa;
        wb_data = wd;
        rd_addr = ra;
        if (w) begin
            mem_m[wa] = wd;
            if (wb_m < 255) wb_m++;
        end
        if (rd_m < 255) rd_m++;
        e.data  = mem_m[ra];
        e.cyc   = cyc + 1 + (w ? 2 * LAT : LAT);
        last_rd = e.data;
        target  = acks_seen + 1;
        sb.push_back(e);
        @(negedge clock); #1;
        req = 1'b0;
        chk("ready_busy", 32'(ready), 32'd0);
        waited = 0;
        while (acks_seen < target && waited < 4 * LAT + 10) begin
            if (scramble) begin
                req     = 1'($urandom_range(0, 1));
                wb_en   = 1'($urandom_range(0, 1));
                wb_addr = AW'($urandom);
                wb_data = DW'($urandom);
                rd_addr = AW'($urandom);
            end
            @(negedge clock); #1;
            waited++;
        end
        req = 1'b0;
        if (acks_seen < target) begin
            chk("ack_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clock); #1;
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("ack_single_pulse", 32'(ack), 32'd0);
        chk("rd_data_held", 32'(rd_data), 32'(last_rd));
    endtask

    initial begin
        logic [AW-1:0] a;
        model_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        #1 resetn = 1'b1;
        check_idle_after_reset("reset");

        // Directed cases.
        txn(1'b0, '0, '0, 5'b10000, 1'b0);
        txn(1'b0, '0, '0, 5'b00101, 1'b0);
        txn(1'b1, 5'b00001, 3'b101, 5'b01001, 1'b1);
        txn(1'b0, '0, '0, 5'b00001, 1'b1);
        txn(1'b1, 5'b01001, 3'b100, 5'b01001, 1'b1);

        // Random traffic, with same-address combined cases mixed in.
        for (int i = 0; i < 150; i++) begin
            a = AW'($urandom);
            if ($urandom_range(0, 3) == 0)
                txn(1'b1, a, DW'($urandom), a, 1'($urandom_range(0, 1)));
            else
                txn(1'($urandom_range(0, 1)), a, DW'($urandom), AW'($urandom),
                    1'($urandom_range(0, 1)));
        end

`ifdef MEMPRINC_STATS_EN
        chk("rd_count_total", 32'(rd_count), 32'(rd_m));
        chk("wb_count_total", 32'(wb_count), 32'(wb_m));
`endif

        // Reset one edge into a write-back: no write, no ack.
        chk("ready_before_abort", 32'(ready), 32'd1);
        req     = 1'b1;
        wb_en   = 1'b1;
        wb_addr = 5'b00001;
        wb_data = 3'b110;
        rd_addr = 5'b00010;
        @(negedge clock); #1;
        req    = 1'b0;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        #1 resetn = 1'b1;
        repeat (2 * LAT + 4) @(negedge clock);
        #1;
        check_idle_after_reset("abort");
        txn(1'b0, '0, '0, 5'b00001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
